// File: rtl/wb_route4.sv
// Four-channel result router: each accepted word lands in a one-entry
// buffer selected by in_sel, and each buffer is drained by its own consumer.
module wb_route4 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       stall_cnt
);

    // Handshake: a word moves when valid and ready are both high at a rising
    // edge; ready never waits on valid, and valid never waits on ready.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state_q [4];
    chan_state_t      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [7:0]       stall_q;
    logic [7:0]       stall_d;
    logic             accept;

    // A full channel can still take a word if its consumer drains this cycle.
    assign in_ready = (state_q[in_sel] == EMPTY) | out_ready[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (state_q[k] == FULL && out_ready[k]) begin
                state_d[k] = EMPTY;
            end
        end
        if (accept) begin
            state_d[in_sel] = FULL;
            data_d[in_sel]  = in_data;
        end
        stall_d = stall_q;
        if (in_valid && !in_ready && stall_q != 8'hFF) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            stall_q <= stall_d;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (state_q[k] == FULL);
        end
    end

    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_wb_route4.sv
// Bench for wb_route4: directed scenarios plus a random phase, checked against
// per-channel delivery queues and a channel-occupancy model.
module tb_wb_route4;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [7:0]   stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference: occupancy, last written word, pending deliveries, stall count.
    bit           m_full [4];
    logic [W-1:0] m_data [4];
    logic [W-1:0] exp_q  [4][$];
    int           m_stall;

    wb_route4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] dut_data(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
            exp_q[k].delete();
        end
        m_stall = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] ev;
        for (int k = 0; k < 4; k++) ev[k] = m_full[k];
        chk({tag, ".out_valid"}, {28'd0, out_valid}, {28'd0, ev});
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.out_data%0d", tag, k), {16'd0, dut_data(k)}, {16'd0, m_data[k]});
        end
        chk({tag, ".stall_cnt"}, {24'd0, stall_cnt}, m_stall);
    endtask

    // One clock: check ready and deliveries before the edge, update the model after.
    task automatic cycle(input string tag);
        logic exp_ready;
        logic acc;
        logic stall;
        logic [3:0] drain;
        #1;
        exp_ready = !m_full[in_sel] || out_ready[in_sel];
        acc       = in_valid && exp_ready;
        stall     = in_valid && !exp_ready;
        for (int k = 0; k < 4; k++) drain[k] = m_full[k] && out_ready[k];
        if (!rst) begin
            chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
            for (int k = 0; k < 4; k++) begin
                if (drain[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("%s.deliver_underflow%0d", tag, k), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("%s.deliver%0d", tag, k), {16'd0, dut_data(k)},
                            {16'd0, exp_q[k].pop_front()});
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) if (drain[k]) m_full[k] = 1'b0;
            if (acc) begin
                m_full[in_sel] = 1'b1;
                m_data[in_sel] = in_data;
                exp_q[in_sel].push_back(in_data);
            end
            if (stall && m_stall < 255) m_stall++;
        end
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd0, '0, 4'h0);
        model_reset();
        #2;
        check_outputs("reset");
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        // Handshake presented while reset is held must not be taken.
        drive(1'b1, 2'd1, 16'h5555, 4'h0);
        cycle("in_reset");
        drive(1'b0, 2'd0, '0, 4'h0);
        rst = 1'b0;

        // Single word to channel 2.
        drive(1'b1, 2'd2, 16'hA5A5, 4'h0);
        cycle("single_a");
        drive(1'b0, 2'd3, 16'hFFFF, 4'hF);
        chk("single.out_valid", {28'd0, out_valid}, 32'h4);
        chk("single.out_data2", {16'd0, out_data2}, 32'hA5A5);
        chk("single.out_data0", {16'd0, out_data0}, 32'h0);
        cycle("single_drain");

        // Backpressure on channel 1, then release with same-cycle accept.
        drive(1'b1, 2'd1, 16'h1111, 4'h0);
        cycle("bp_fill");
        drive(1'b1, 2'd1, 16'h2222, 4'h0);
        for (int i = 0; i < 5; i++) cycle("bp_hold");
        chk("bp.stall_5", {24'd0, stall_cnt}, 32'd5);
        chk("bp.data_held", {16'd0, out_data1}, 32'h1111);
        out_ready = 4'b0010;
        cycle("bp_release");
        chk("bp.new_word", {16'd0, out_data1}, 32'h2222);
        chk("bp.still_full", {31'd0, out_valid[1]}, 32'd1);
        drive(1'b0, 2'd0, '0, 4'hF);
        cycle("bp_drain");

        // Full-throughput stream across all channels.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'((i - 1) % 4), 16'(i), 4'hF);
            cycle("stream");
        end
        drive(1'b0, 2'd0, '0, 4'hF);
        cycle("stream_tail");
        for (int k = 0; k < 4; k++) chk($sformatf("stream.lost%0d", k), exp_q[k].size(), 0);

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  16'($urandom), 4'($urandom_range(0, 15)));
            cycle("random");
        end

        // Stall counter saturation with every channel full.
        drive(1'b0, 2'd0, '0, 4'hF);
        cycle("sat_clear");
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 16'(16'h0100 + k), 4'h0);
            cycle("sat_fill");
        end
        drive(1'b1, 2'd2, 16'hDEAD, 4'h0);
        for (int i = 0; i < 300; i++) cycle("sat_hold");
        chk("sat.stall_255", {24'd0, stall_cnt}, 32'd255);

        // Asynchronous reset with channels 0 and 3 full.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        drive(1'b1, 2'd0, 16'h0C0C, 4'h0);
        cycle("ar_fill0");
        drive(1'b1, 2'd3, 16'h3C3C, 4'h0);
        cycle("ar_fill3");
        drive(1'b0, 2'd0, '0, 4'h0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 2'd3, 16'hBEEF, 4'h0);
        cycle("post_rst");
        chk("post_rst.out_valid", {28'd0, out_valid}, 32'h8);
        chk("post_rst.out_data3", {16'd0, out_data3}, 32'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_route4.md
WB_ROUTE4 -- requirements
Module: wb_route4

Interface
REQ-001 Parameter: WIDTH, 16, data width of input and of each output channel.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_data  input  WIDTH  result word to be routed.
REQ-005 Port: in_sel  input  2  destination channel index 0..3.
REQ-006 Port: in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts the word this cycle.
REQ-008 Port: out_data0..out_data3  output  WIDTH each  per-channel buffered word.
REQ-009 Port: out_valid  output  4  bit k = channel k holds an undelivered word.
REQ-010 Port: out_ready  input  4  bit k = consumer k takes the word this cycle.
REQ-011 Port: stall_cnt  output  8  saturating count of cycles with input stalled.

Function
REQ-012 Each channel k SHALL be a one-entry buffer with two states, EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-013 in_ready SHALL equal (~out_valid[in_sel]) | out_ready[in_sel], combinationally, regardless of in_valid.
REQ-014 Accept = in_valid & in_ready; on accept, in_data SHALL be written to channel in_sel at the next rising edge and out_valid[in_sel] SHALL be 1 from that edge (latency 1 cycle).
REQ-015 Drain of channel k = out_valid[k] & out_ready[k]; on drain without simultaneous accept to k, channel k SHALL go EMPTY at the next edge.
REQ-016 Simultaneous drain and accept on the same channel SHALL leave it FULL with the new word (full throughput, one word per cycle per channel).
REQ-017 Accepts to channel j and drains of channels k != j in the same cycle SHALL proceed independently; all four channels may drain in one cycle.
REQ-018 out_data[k] SHALL hold stable while out_valid[k]=1 and out_ready[k]=0.
REQ-019 out_data[k] SHALL retain its last written value after drain (not cleared); it is meaningless while out_valid[k]=0.
REQ-020 Channels not addressed by an accept SHALL keep their data and state unchanged.
REQ-021 out_ready[k] while out_valid[k]=0 SHALL have no effect.
REQ-022 in_sel and in_data SHALL be ignored when in_valid=0; no state changes.
REQ-023 stall_cnt SHALL increment by 1 at each edge where in_valid=1 and in_ready=0, and SHALL saturate at 255 (no wrap).
REQ-024 No output other than in_ready SHALL depend combinationally on inputs.

Reset
REQ-025 On rst=1, asynchronously: out_valid=4'b0000, out_data0..3=0, stall_cnt=0; consequently in_ready=1.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words with no delivery; a handshake coincident with the reset-deassertion edge SHALL NOT be taken.
REQ-027 First accept SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-028 Reset, then in_data=16'hA5A5, in_sel=2, in_valid=1 one cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=16'hA5A5, others 0, stall_cnt=0.
REQ-029 Channel 1 FULL, out_ready=0, in_sel=1, in_valid=1 held 5 cycles -> in_ready=0 throughout, out_data1 unchanged, stall_cnt=5; then out_ready[1]=1 -> word accepted same cycle, out_data1 = new word next cycle, out_valid[1] stays 1.
REQ-030 out_ready=4'b1111, stream 16'h0001..16'h0008 with in_sel cycling 0,1,2,3 -> in_ready=1 every cycle, each word appears on its channel exactly one cycle after acceptance, no loss.
REQ-031 All channels FULL, out_ready=4'b0000, in_valid=1 held 300 cycles -> stall_cnt reaches 255 and holds 255.
REQ-032 Channels 0 and 3 FULL, assert rst asynchronously between edges -> out_valid=0, out_data0..3=0, stall_cnt=0 immediately; after deassert, accept to channel 3 succeeds on the first edge.
